// File: rtl/edisk_multi_ctrl_pkg.sv
// Shared constants for the E-disk mapper: control-register bit positions,
// disk-count limit and the ed_page width helper.
package edisk_multi_ctrl_pkg;

  localparam int MAX_DISKS = 8;

  // Control register layout, one byte per disk
  localparam int CTL_WIN_E000  = 7;  // window also covers E000-FFFF
  localparam int CTL_WIN_8000  = 6;  // window also covers 8000-9FFF
  localparam int CTL_WIN_EN    = 5;  // window enable (A000-DFFF always mapped)
  localparam int CTL_STK_EN    = 4;  // stack enable
  localparam int CTL_STK_PG_LO = 2;  // [3:2] stack page
  localparam int CTL_WIN_PG_LO = 0;  // [1:0] window page

  // Width of ed_page: pages 1..4*n plus the "main RAM" code 0
  function automatic int page_w(input int n);
    return $clog2(4 * n + 1);
  endfunction

endpackage

// File: rtl/edisk_multi_ctrl_if.sv
// CPU-side bus of the E-disk mapper: IO port decode, status word, memory
// address and the page/readback results.
interface edisk_multi_ctrl_if #(
  parameter int NUM_DISKS = 4
) ();
  import edisk_multi_ctrl_pkg::*;

  localparam int PW = page_w(NUM_DISKS);

  logic [7:0]    io_addr;
  logic          io_wr;
  logic          io_rd;
  logic [7:0]    din;
  logic [7:0]    dout;
  logic          sel;
  logic [15:0]   addr;
  logic          ram_read;
  logic          write_n;
  logic          io_stack;
  logic [PW-1:0] ed_page;
  logic          ed_active;

  modport master (
    output io_addr, io_wr, io_rd, din, addr, ram_read, write_n, io_stack,
    input  dout, sel, ed_page, ed_active
  );

  modport slave (
    input  io_addr, io_wr, io_rd, din, addr, ram_read, write_n, io_stack,
    output dout, sel, ed_page, ed_active
  );

endinterface

// File: rtl/edisk_multi_ctrl_decode.sv
// Per-disk hit decode: from one control byte, the top address bits and the
// CPU status word, flag a stack or window hit and pick the 2-bit page.
module edisk_multi_ctrl_decode (
  input  logic [7:0] i_ctl,
  input  logic [2:0] i_addr_hi,   // addr[15:13]
  input  logic       i_mem,       // memory cycle (read or write)
  input  logic       i_io_stack,
  output logic       o_stk_hit,
  output logic       o_win_hit,
  output logic [1:0] o_page
);
  import edisk_multi_ctrl_pkg::*;

  logic w_region;

  // A000-DFFF always; E000-FFFF and 8000-9FFF only when their bits are set
  assign w_region = (i_addr_hi[1] ^ i_addr_hi[0])
                  | (i_ctl[CTL_WIN_E000] &  i_addr_hi[1] &  i_addr_hi[0])
                  | (i_ctl[CTL_WIN_8000] & ~i_addr_hi[1] & ~i_addr_hi[0]);

  assign o_stk_hit = i_ctl[CTL_STK_EN] & i_io_stack & i_mem;
  assign o_win_hit = i_ctl[CTL_WIN_EN] & i_mem & i_addr_hi[2] & w_region;

  // A disk chosen for a window hit never has a stack hit, so one page mux suffices
  assign o_page = o_stk_hit ? i_ctl[CTL_STK_PG_LO +: 2] : i_ctl[CTL_WIN_PG_LO +: 2];

endmodule

// File: rtl/edisk_multi_ctrl.sv
// Multi-channel E-disk mapper: one control register per 256KB disk, written
// through consecutive IO ports, mapped into CPU stack/window cycles to form
// the SDRAM page index prepended to the CPU address.
module edisk_multi_ctrl #(
  parameter int         NUM_DISKS = 4,
  parameter logic [7:0] BASE_PORT = 8'h10,
  parameter bit         EXCLUSIVE = 1'b0,
  parameter bit         READBACK  = 1'b1
) (
  input logic               clk_sys,
  input logic               reset_n,
  edisk_multi_ctrl_if.slave bus
);
  import edisk_multi_ctrl_pkg::*;

  localparam int PW = page_w(NUM_DISKS);

  logic [7:0]           r_ctl [NUM_DISKS];
  logic                 r_old_we;
  logic [7:0]           w_idx;
  logic                 w_sel;
  logic                 w_wr_hit;
  logic                 w_wr_edge;
  logic                 w_mem;
  logic                 w_excl_clr;
  logic [NUM_DISKS-1:0] w_stk;
  logic [NUM_DISKS-1:0] w_win;
  logic [1:0]           w_dpage [NUM_DISKS];
  logic [PW-1:0]        w_page;
  logic [7:0]           w_rd;
  logic                 w_unused;

  assign w_idx      = bus.io_addr - BASE_PORT;
  assign w_sel      = (w_idx < 8'(NUM_DISKS));
  assign w_wr_hit   = bus.io_wr & w_sel;
  assign w_wr_edge  = w_wr_hit & ~r_old_we;
  assign w_mem      = bus.ram_read | ~bus.write_n;
  assign w_excl_clr = EXCLUSIVE & (bus.din[CTL_WIN_EN] | bus.din[CTL_STK_EN]);

  // Register file: one write per rising edge of the port strobe, plus exclusive clear
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_old_we <= 1'b0;
      // NOTE: the register file is a handful of flops, not a RAM, so it is reset here
      for (int i = 0; i < NUM_DISKS; i++) r_ctl[i] <= 8'h00;
    end else begin
      // NOTE: non-blocking updates so every disk sees the same pre-edge state
      r_old_we <= w_wr_hit;
      for (int i = 0; i < NUM_DISKS; i++) begin
        if (w_wr_edge && (w_idx == 8'(i))) begin
          r_ctl[i] <= bus.din;
        end else if (w_wr_edge && w_excl_clr) begin
          r_ctl[i][CTL_WIN_EN] <= 1'b0;
          r_ctl[i][CTL_STK_EN] <= 1'b0;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_DISKS; g++) begin : g_dec
    edisk_multi_ctrl_decode u_dec (
      .i_ctl      (r_ctl[g]),
      .i_addr_hi  (bus.addr[15:13]),
      .i_mem      (w_mem),
      .i_io_stack (bus.io_stack),
      .o_stk_hit  (w_stk[g]),
      .o_win_hit  (w_win[g]),
      .o_page     (w_dpage[g])
    );
  end

  // Priority encode: any stack hit beats any window hit, lowest disk wins
  always_comb begin
    // NOTE: default first so no path leaves w_page unassigned (no latch)
    w_page = '0;
    if (|w_stk) begin
      for (int i = NUM_DISKS - 1; i >= 0; i--)
        if (w_stk[i]) w_page = PW'(1 + 4 * i) + PW'(w_dpage[i]);
    end else begin
      for (int i = NUM_DISKS - 1; i >= 0; i--)
        if (w_win[i]) w_page = PW'(1 + 4 * i) + PW'(w_dpage[i]);
    end
  end

  // Readback mux: selected control byte, or FF when off-range, disabled or in reset
  always_comb begin
    w_rd = 8'hFF;
    if (reset_n && w_sel && READBACK) begin
      for (int i = 0; i < NUM_DISKS; i++)
        if (w_idx == 8'(i)) w_rd = r_ctl[i];
    end
  end

  assign bus.dout      = w_rd;
  assign bus.sel       = w_sel;
  assign bus.ed_page   = w_page;
  assign bus.ed_active = |w_page;

  // io_rd has no side effects and only addr[15:13] selects a region
  assign w_unused = &{1'b0, bus.io_rd, bus.addr[12:0]};

endmodule

// File: tb/tb_edisk_multi_ctrl.sv
// Bench for edisk_multi_ctrl: four instances (N=4, N=4 exclusive, N=8,
// N=4 without readback) share one stimulus stream; a behavioural model of
// each instance is compared on every cycle, plus hand-computed spot checks.
module tb_edisk_multi_ctrl;

  localparam logic [3:0] CFG_X = 4'b0010;  // instance 1 exclusive
  localparam logic [3:0] CFG_R = 4'b0111;  // instance 3 no readback

  function automatic int cfg_n(input int g);
    return (g == 2) ? 8 : 4;
  endfunction

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic [7:0]  t_io_addr;
  logic        t_io_wr;
  logic        t_io_rd;
  logic [7:0]  t_din;
  logic [15:0] t_addr;
  logic        t_ram_read;
  logic        t_write_n;
  logic        t_io_stack;

  logic [7:0]  o_page [4];
  logic        o_act  [4];
  logic        o_sel  [4];
  logic [7:0]  o_dout [4];

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk_sys = ~clk_sys;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    edisk_multi_ctrl_if #(.NUM_DISKS(cfg_n(g))) bus ();

    assign bus.io_addr  = t_io_addr;
    assign bus.io_wr    = t_io_wr;
    assign bus.io_rd    = t_io_rd;
    assign bus.din      = t_din;
    assign bus.addr     = t_addr;
    assign bus.ram_read = t_ram_read;
    assign bus.write_n  = t_write_n;
    assign bus.io_stack = t_io_stack;

    assign o_page[g] = 8'(bus.ed_page);
    assign o_act[g]  = bus.ed_active;
    assign o_sel[g]  = bus.sel;
    assign o_dout[g] = bus.dout;

    edisk_multi_ctrl #(
      .NUM_DISKS (cfg_n(g)),
      .BASE_PORT (8'h10),
      .EXCLUSIVE (CFG_X[g]),
      .READBACK  (CFG_R[g])
    ) dut (
      .clk_sys (clk_sys),
      .reset_n (reset_n),
      .bus     (bus)
    );
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] m_ctl  [4][8];
  logic       m_prev [4];

  function automatic bit exp_sel(input int g);
    int a = int'(t_io_addr);
    return (a >= 16) && (a < 16 + cfg_n(g));
  endfunction

  function automatic int exp_page(input int g);
    int a = int'(t_addr);
    int c;
    if (!(t_ram_read || !t_write_n)) return 0;
    if (t_io_stack)
      for (int i = 0; i < cfg_n(g); i++)
        if (m_ctl[g][i][4]) return 1 + 4 * i + int'(m_ctl[g][i][3:2]);
    for (int i = 0; i < cfg_n(g); i++) begin
      c = int'(m_ctl[g][i]);
      if ((c & 'h20) != 0 && a >= 'h8000) begin
        if ((a >= 'hA000 && a < 'hE000) ||
            (a >= 'hE000 && (c & 'h80) != 0) ||
            (a <  'hA000 && (c & 'h40) != 0))
          return 1 + 4 * i + (c & 3);
      end
    end
    return 0;
  endfunction

  function automatic int exp_dout(input int g);
    if (!reset_n || !exp_sel(g) || !CFG_R[g]) return 'hFF;
    return int'(m_ctl[g][int'(t_io_addr) - 16]);
  endfunction

  // Model state: writes land on the edge after the strobe first hits a valid port
  always @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      for (int g = 0; g < 4; g++) begin
        m_prev[g] <= 1'b0;
        for (int i = 0; i < 8; i++) m_ctl[g][i] <= 8'h00;
      end
    end else begin
      for (int g = 0; g < 4; g++) begin
        m_prev[g] <= t_io_wr && exp_sel(g);
        if (t_io_wr && exp_sel(g) && !m_prev[g]) begin
          m_ctl[g][int'(t_io_addr) - 16] <= t_din;
          if (CFG_X[g] && (t_din & 8'h30) != 0)
            for (int j = 0; j < cfg_n(g); j++)
              if (j != int'(t_io_addr) - 16) m_ctl[g][j] <= m_ctl[g][j] & 8'hCF;
        end
      end
    end
  end

  // Every-cycle compare, away from the active edge
  always @(negedge clk_sys) begin
    for (int g = 0; g < 4; g++) begin
      check($sformatf("page[%0d]", g), o_page[g], exp_page(g));
      check($sformatf("active[%0d]", g), o_act[g], exp_page(g) != 0);
      check($sformatf("sel[%0d]", g), o_sel[g], exp_sel(g));
      check($sformatf("dout[%0d]", g), o_dout[g], exp_dout(g));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk_sys);
      #2;
    end
  endtask

  task automatic io_write(input logic [7:0] port, input logic [7:0] data);
    tick();
    t_io_addr = port;
    t_din     = data;
    t_io_wr   = 1'b1;
    tick(3);
    t_io_wr   = 1'b0;
    tick();
  endtask

  task automatic mem(input logic [15:0] a, input logic rr, input logic wn, input logic stk);
    tick();
    t_addr     = a;
    t_ram_read = rr;
    t_write_n  = wn;
    t_io_stack = stk;
    #1;
  endtask

  task automatic rd(input logic [7:0] port);
    tick();
    t_io_addr = port;
    t_io_rd   = 1'b1;
    #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset_n    = 1'b0;
    t_io_addr  = 8'h00;
    t_io_wr    = 1'b0;
    t_io_rd    = 1'b0;
    t_din      = 8'h00;
    t_addr     = 16'h0000;
    t_ram_read = 1'b0;
    t_write_n  = 1'b1;
    t_io_stack = 1'b0;
    tick(3);
    reset_n = 1'b1;

    rd(8'h12);
    check("rst_read_d0", o_dout[0], 8'h00);
    check("rst_sel_d0",  o_sel[0],  1);

    // Basic window mapping on disk 1
    io_write(8'h11, 8'h21);
    mem(16'hA000, 1'b1, 1'b1, 1'b0);
    check("a000_d0", o_page[0], 6);
    check("a000_d2", o_page[2], 6);
    check("a000_act_d0", o_act[0], 1);
    mem(16'h8000, 1'b1, 1'b1, 1'b0);
    check("8000_off", o_page[0], 0);
    mem(16'hA000, 1'b0, 1'b1, 1'b0);
    check("no_mem", o_page[0], 0);
    mem(16'hC000, 1'b0, 1'b0, 1'b0);
    check("write_cycle", o_page[0], 6);
    io_write(8'h11, 8'h61);
    mem(16'h8000, 1'b1, 1'b1, 1'b0);
    check("8000_on", o_page[0], 6);
    mem(16'hE000, 1'b1, 1'b1, 1'b0);
    check("e000_off", o_page[0], 0);
    io_write(8'h11, 8'hA1);
    mem(16'hE000, 1'b1, 1'b1, 1'b0);
    check("e000_on", o_page[0], 6);

    // Stack beats window
    io_write(8'h11, 8'h00);
    io_write(8'h10, 8'h1C);
    io_write(8'h12, 8'h20);
    mem(16'hC000, 1'b1, 1'b1, 1'b1);
    check("stk_prio_d0", o_page[0], 4);
    check("stk_excl_d1", o_page[1], 9);
    mem(16'hC000, 1'b1, 1'b1, 1'b0);
    check("win_only_d0", o_page[0], 9);
    mem(16'hC000, 1'b0, 1'b1, 1'b1);
    check("stk_no_mem", o_page[0], 0);

    // Held strobe writes once
    tick();
    t_io_addr = 8'h13;
    t_din     = 8'h25;
    t_io_wr   = 1'b1;
    tick(2);
    t_din     = 8'h3A;
    tick(30);
    t_io_wr   = 1'b0;
    tick();
    rd(8'h13);
    check("held_wr_d0", o_dout[0], 8'h25);

    // Exclusive mode clears the other disk
    io_write(8'h11, 8'h20);
    io_write(8'h13, 8'h10);
    rd(8'h11);
    check("excl_d1", o_dout[1], 8'h00);
    check("nonexcl_d0", o_dout[0], 8'h20);
    rd(8'h13);
    check("excl_own_d1", o_dout[1], 8'h10);

    // Boundary: last port of an 8-disk instance, first port past it
    for (int p = 0; p < 4; p++) io_write(8'(8'h10 + p), 8'h00);
    io_write(8'h17, 8'h23);
    mem(16'hB000, 1'b1, 1'b1, 1'b0);
    check("top_page_d2", o_page[2], 32);
    check("top_page_d0", o_page[0], 0);
    rd(8'h17);
    check("rd17_d2", o_dout[2], 8'h23);
    check("sel17_d0", o_sel[0], 0);
    check("rd17_d0", o_dout[0], 8'hFF);
    io_write(8'h18, 8'hFF);
    rd(8'h18);
    check("sel18_d2", o_sel[2], 0);
    check("rd18_d2", o_dout[2], 8'hFF);
    check("page_after18_d2", o_page[2], 32);
    rd(8'h10);
    check("noreadback_d3", o_dout[3], 8'hFF);
    check("noreadback_sel_d3", o_sel[3], 1);

    // Asynchronous reset in the middle of an access
    rd(8'h17);
    check("pre_rst_d2", o_page[2], 32);
    #1;
    reset_n = 1'b0;
    #1;
    check("async_rst_page", o_page[2], 0);
    check("async_rst_act", o_act[2], 0);
    check("async_rst_dout", o_dout[2], 8'hFF);
    tick(2);
    reset_n = 1'b1;
    rd(8'h17);
    check("post_rst_rd", o_dout[2], 8'h00);
    check("post_rst_page", o_page[2], 0);

    tick(2);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
